// File: rtl/fifo_flush_pack_if.sv
// Handshake and status bundle for fifo_flush_pack: narrow write beats in, wide words out.
interface fifo_flush_pack_if #(
  parameter int DATA_W = 4,
  parameter int PACK   = 8,
  parameter int DEPTH  = 4
) ();
  logic                         fifo_wr_valid_i;
  logic [DATA_W-1:0]            fifo_wr_data_i;
  logic                         fifo_wr_ready_o;
  logic                         fifo_rd_valid_i;
  logic [DATA_W*PACK-1:0]       fifo_rd_data_o;
  logic                         fifo_flush_i;
  logic                         fifo_flush_done_o;
  logic                         fifo_data_avail_o;
  logic                         fifo_empty_o;
  logic                         fifo_full_o;
  logic [$clog2(DEPTH+1)-1:0]   fifo_level_o;

  modport slave (
    input  fifo_wr_valid_i, fifo_wr_data_i, fifo_rd_valid_i, fifo_flush_i,
    output fifo_wr_ready_o, fifo_rd_data_o, fifo_flush_done_o, fifo_data_avail_o,
           fifo_empty_o, fifo_full_o, fifo_level_o
  );

  modport master (
    output fifo_wr_valid_i, fifo_wr_data_i, fifo_rd_valid_i, fifo_flush_i,
    input  fifo_wr_ready_o, fifo_rd_data_o, fifo_flush_done_o, fifo_data_avail_o,
           fifo_empty_o, fifo_full_o, fifo_level_o
  );
endinterface

// File: rtl/fifo_flush_pack.sv
// Packs narrow beats LSB-first into wide words, buffers them, and flushes partial words on request.
// Define FIFO_FLUSH_DISCARD_EN to make a flush drop all buffered data instead of padding and draining.
module fifo_flush_pack #(
  parameter int DATA_W = 4,
  parameter int PACK   = 8,
  parameter int DEPTH  = 4
) (
  input  logic               clock,
  input  logic               reset,
  fifo_flush_pack_if.slave   bus
);
  localparam int OUT_W = DATA_W * PACK;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int CW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);

  typedef enum logic [1:0] {IDLE, PAD, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [OUT_W-1:0]  acc;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [OUT_W-1:0]  mem [DEPTH];
  logic [OUT_W-1:0]  rd_word;
  logic [OUT_W-1:0]  beat_word, push_word;
  logic              empty, full, pop_req, pop, push_ok, push;
  logic              accept, beat_last, pad_push, discard, cnt_nz_after;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_req = bus.fifo_rd_valid_i && !empty;
  assign push_ok = !full || pop_req;

`ifdef FIFO_FLUSH_DISCARD_EN
  assign discard = (state == IDLE) && bus.fifo_flush_i;
`else
  assign discard = 1'b0;
`endif

  // A discarding flush suppresses any read or write landing on the same edge
  assign pop       = pop_req && !discard;
  assign bus.fifo_wr_ready_o = (state == IDLE) && ((cnt != LAST) || push_ok);
  assign accept    = bus.fifo_wr_valid_i && bus.fifo_wr_ready_o && !discard;
  assign beat_last = accept && (cnt == LAST);
  assign pad_push  = (state == PAD) && push_ok;
  assign push      = beat_last || pad_push;

  always_comb begin
    beat_word = acc;
    beat_word[(PACK-1)*DATA_W +: DATA_W] = bus.fifo_wr_data_i;
  end

  // Slices above cnt are already zero, so acc is the padded partial word as-is
  assign push_word = pad_push ? acc : beat_word;

  // Packer occupancy after this edge, so a beat accepted alongside the flush is not stranded
  assign cnt_nz_after = accept ? (cnt != LAST) : (cnt != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.fifo_flush_i) begin
`ifdef FIFO_FLUSH_DISCARD_EN
          state_nxt = DONE;
`else
          state_nxt = cnt_nz_after ? PAD : DRAIN;
`endif
        end
      end
      PAD:     if (push_ok) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    if (!bus.fifo_flush_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      acc     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_word <= '0;
    end else begin
      if (discard) begin
        cnt    <= '0;
        acc    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          cnt <= '0;
          acc <= '0;
        end else if (accept) begin
          acc[int'(cnt)*DATA_W +: DATA_W] <= bus.fifo_wr_data_i;
          cnt <= cnt + 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) rd_word <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  assign bus.fifo_rd_data_o    = rd_word;
  assign bus.fifo_flush_done_o = (state == DONE);
  assign bus.fifo_data_avail_o = !empty;
  assign bus.fifo_empty_o      = empty;
  assign bus.fifo_full_o       = full;
  assign bus.fifo_level_o      = LW'(wr_ptr - rd_ptr);
endmodule

// File: tb/tb_fifo_flush_pack.sv
// Bench for fifo_flush_pack: directed and random steps checked against a queue-based model.
module tb_fifo_flush_pack;
  localparam int DATA_W = 4;
  localparam int PACK   = 8;
  localparam int DEPTH  = 4;
  localparam int OUT_W  = DATA_W * PACK;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fifo_flush_pack_if #(.DATA_W(DATA_W), .PACK(PACK), .DEPTH(DEPTH)) bus ();

  fifo_flush_pack #(.DATA_W(DATA_W), .PACK(PACK), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: buffered words, pending beats and flush progress
  logic [OUT_W-1:0]  q[$];
  logic [DATA_W-1:0] beats[$];
  bit                flushing, pad_pending, done_m;
  logic [OUT_W-1:0]  exp_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [OUT_W-1:0] packed_word();
    logic [OUT_W-1:0] w = '0;
    foreach (beats[i]) w[i*DATA_W +: DATA_W] = beats[i];
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    beats.delete();
    flushing = 0;
    pad_pending = 0;
    done_m = 0;
    exp_rd = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_level"}, 64'(bus.fifo_level_o), 64'(q.size()));
    check({tag, "_empty"}, 64'(bus.fifo_empty_o), 64'(q.size() == 0));
    check({tag, "_full"},  64'(bus.fifo_full_o),  64'(q.size() == DEPTH));
    check({tag, "_avail"}, 64'(bus.fifo_data_avail_o), 64'(q.size() != 0));
    check({tag, "_rd_data"}, 64'(bus.fifo_rd_data_o), 64'(exp_rd));
    check({tag, "_done"},  64'(bus.fifo_flush_done_o), 64'(done_m));
  endtask

  task automatic step(input logic wv, input logic [DATA_W-1:0] wd, input logic rv, input logic fl);
    int qn;
    bit idle_m, disc, pop_m, acc_m, drain_m, exp_ready;
    @(negedge clock);
    bus.fifo_wr_valid_i = wv;
    bus.fifo_wr_data_i  = wd;
    bus.fifo_rd_valid_i = rv;
    bus.fifo_flush_i    = fl;
    #1;
    qn      = q.size();
    idle_m  = !flushing && !done_m;
`ifdef FIFO_FLUSH_DISCARD_EN
    disc = idle_m && fl;
`else
    disc = 0;
`endif
    exp_ready = idle_m && (beats.size() != PACK-1 || qn < DEPTH || (rv && qn > 0));
    check("ready", 64'(bus.fifo_wr_ready_o), 64'(exp_ready));
    pop_m   = rv && qn > 0 && !disc;
    acc_m   = wv && exp_ready && !disc;
    drain_m = flushing && !pad_pending;
    if (pop_m) exp_rd = q.pop_front();
    if (acc_m) begin
      beats.push_back(wd);
      if (beats.size() == PACK) begin
        q.push_back(packed_word());
        beats.delete();
      end
    end
    if (flushing && pad_pending && (qn < DEPTH || pop_m)) begin
      q.push_back(packed_word());
      beats.delete();
      pad_pending = 0;
    end
    if (drain_m && qn == 0) begin
      done_m = 1;
      flushing = 0;
    end else if (done_m && !fl) begin
      done_m = 0;
    end else if (idle_m && fl) begin
      if (disc) begin
        q.delete();
        beats.delete();
        done_m = 1;
      end else begin
        flushing = 1;
        pad_pending = (beats.size() != 0);
      end
    end
    @(posedge clock);
    #1;
    check_outputs("step");
  endtask

  initial begin
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_wr_data_i  = '0;
    bus.fifo_rd_valid_i = 1'b0;
    bus.fifo_flush_i    = 1'b0;
    model_reset();

    // Reset and defaults
    repeat (2) @(posedge clock);
    #1;
    check_outputs("in_reset");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 64'(bus.fifo_wr_ready_o), 64'd1);

    // Partial word flush: A,6,8
    step(1, 4'hA, 0, 0);
    step(1, 4'h6, 0, 0);
    step(1, 4'h8, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
`ifndef FIFO_FLUSH_DISCARD_EN
    check("partial_word", 64'(bus.fifo_rd_data_o), 64'h0000086A);
`endif
    for (int i = 0; i < 20 && !bus.fifo_flush_done_o; i++) step(0, 0, 0, 1);
    check("partial_done", 64'(bus.fifo_flush_done_o), 64'd1);
    step(0, 0, 0, 0);
    check("done_clears", 64'(bus.fifo_flush_done_o), 64'd0);

    // Full word 1..8
    for (int b = 1; b <= PACK; b++) step(1, DATA_W'(b), 0, 0);
    check("word_avail", 64'(bus.fifo_data_avail_o), 64'd1);
    step(0, 0, 1, 0);
    check("word_value", 64'(bus.fifo_rd_data_o), 64'h87654321);

    // Fill FIFO, then stall on the completing beat until a pop frees room
    for (int b = 0; b < DEPTH*PACK; b++) step(1, DATA_W'($urandom), 0, 0);
    check("full_set", 64'(bus.fifo_full_o), 64'd1);
    for (int b = 0; b < PACK-1; b++) step(1, DATA_W'($urandom), 0, 0);
    step(1, DATA_W'($urandom), 0, 0);
    step(1, DATA_W'($urandom), 1, 0);
    check("push_pop_level", 64'(bus.fifo_level_o), 64'(DEPTH));

    // Flush with full FIFO plus a partial word
    for (int b = 0; b < 3; b++) step(1, DATA_W'($urandom), 0, 0);
    repeat (4) step(0, 0, 0, 1);
    for (int i = 0; i < 30 && !bus.fifo_flush_done_o; i++) step(0, 0, 1, 1);
    check("full_flush_done", 64'(bus.fifo_flush_done_o), 64'd1);
    step(0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 19) == 0));

    // Reset asserted while draining
    for (int i = 0; i < 60 && (flushing || done_m || q.size() != 0); i++) step(0, 0, 1, 0);
    for (int b = 0; b < PACK; b++) step(1, DATA_W'($urandom), 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    bus.fifo_flush_i    = 1'b0;
    bus.fifo_wr_valid_i = 1'b0;
    bus.fifo_rd_valid_i = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_after_reset2", 64'(bus.fifo_wr_ready_o), 64'd1);
    step(0, 0, 0, 0);
    step(1, 4'h3, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_flush_pack.md
# fifo_flush_pack

Parametrised successor to the single-configuration flush FIFO. Narrow write beats are packed LSB-first into wide words, and the words are buffered in a DEPTH-entry FIFO. A flush request zero-pads and commits any partial word, then drains the FIFO through normal reads and signals completion. The block sits between a narrow producer and a 32-bit-class consumer that must see every accepted beat, including trailing partial words.

## Interface
- DATA_W, 4: width of one write beat.
- PACK, 8: beats per output word; output word width OUT_W = DATA_W*PACK.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fifo_wr_valid_i  in  1  write beat offered.
- fifo_wr_data_i  in  DATA_W  write beat.
- fifo_wr_ready_o  out  1  beat accepted this cycle when high with valid.
- fifo_rd_valid_i  in  1  pop request.
- fifo_rd_data_o  out  OUT_W  registered popped word.
- fifo_flush_i  in  1  flush request, level.
- fifo_flush_done_o  out  1  flush complete, held until fifo_flush_i drops.
- fifo_data_avail_o  out  1  FIFO holds ≥1 word.
- fifo_empty_o / fifo_full_o  out  1  FIFO count == 0 / == DEPTH.
- fifo_level_o  out  $clog2(DEPTH+1)  FIFO word count.

## Operation
- Packer: beat index cnt (0..PACK-1), accumulator acc. Accepted beat goes to slice cnt (slice 0 = bits DATA_W-1:0). On beat PACK-1, {beat, acc} is pushed into the FIFO on the same edge, and cnt and acc clear.
- push_ok = !full || pop_this_cycle. Ready rule: fifo_wr_ready_o = (state==IDLE) && (cnt!=PACK-1 || push_ok). Beats offered while not ready are dropped by the producer's handshake; they are not lost internally.
- Pop: a pop occurs when fifo_rd_valid_i && !empty. The head word is loaded into fifo_rd_data_o at the edge, and the read pointer advances. fifo_rd_data_o holds its value otherwise. A pop request while empty is ignored.
- Simultaneous push and pop: the level is unchanged, and both are legal at full.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full/empty are derived from the MSB compare.
- Flush FSM:
  - IDLE: on fifo_flush_i, go to PAD if cnt!=0, else DRAIN.
  - PAD: push acc with upper slices zero once push_ok; clear cnt; go to DRAIN. It waits while full with no pop.
  - DRAIN: go to DONE when empty (pops continue normally).
  - DONE: fifo_flush_done_o=1; return to IDLE when fifo_flush_i=0.
- Writes are blocked (ready=0) in PAD, DRAIN and DONE.
- fifo_flush_i deasserting mid-flush does not abort the flush. The FSM completes the flush and then returns directly from DONE to IDLE.
- Reset (any time, including mid-flush): state=IDLE, cnt=0, acc=0, pointers=0, fifo_rd_data_o=0, fifo_flush_done_o=0, fifo_wr_ready_o=1 after release, fifo_empty_o=1, fifo_full_o=0, fifo_data_avail_o=0, fifo_level_o=0. FIFO storage need not be reset.

## Timing
- Beat to word visible as data_avail: 1 cycle after the edge accepting beat PACK-1.
- Pop to data: fifo_rd_data_o is valid 1 cycle after the pop request edge.
- Flush done latency with an empty packer and empty FIFO: done high 2 edges after fifo_flush_i is sampled (IDLE→DRAIN→DONE).
- PAD push completes in 1 cycle when not full.
- All outputs except fifo_wr_ready_o are registered or derived from registers only. fifo_wr_ready_o is combinational on state, cnt, full and fifo_rd_valid_i.

## Configuration
- FIFO_FLUSH_DISCARD_EN defined:
  - Flush discards data: IDLE→DONE in one edge.
  - On that edge, cnt, acc and both pointers clear. fifo_rd_data_o is unchanged.
  - No padded word is pushed, and reads in that cycle are ignored.
- Macro undefined: pad-and-drain behaviour as specified above.

## Test plan
- Reset and defaults: hold reset=0 for 2 cycles, then release. All outputs take their reset values, and ready=1.
- Partial flush: write A,6,8, then assert flush. The FSM passes through PAD. A pop then returns 0x0000086A, and done rises once the FIFO is empty. Drop flush, and done clears the next cycle.
- Full word: write 8 beats 1..8. data_avail=1 one cycle later. A pop returns 0x87654321.
- Full FIFO: write 4*8 beats with no pops. full=1, and ready=0 during the next beat PACK-1 (cnt=7) until a pop in the same cycle, then push and pop complete together with the level held at 4.
- Flush with full FIFO plus a partial word: PAD waits, and pops drain 5 words in order with the padded word last. done follows empty.
- Reset asserted in DRAIN: outputs return to reset values asynchronously, and the FSM is in IDLE after release. With FIFO_FLUSH_DISCARD_EN, the same partial flush yields done after 1 edge, with level=0 and no padded word.
